// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder sweep controller: command modes, completion
// status codes, controller states and the default decoder address width.
package decoder_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 6;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_BADMODE = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StActive = 2'b01,
    StFin    = 2'b10
  } state_e;

endpackage

// File: rtl/decoder_dwell_cnt.sv
// Loadable down-counter with a zero flag, used to time how long each address is held.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   load_i         load load_val_i (takes priority over dec_i)
//   load_val_i     value to load
//   dec_i          decrement by one; ignored when already zero
//   zero_o         count register is zero
module decoder_dwell_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_sweep_ctrl.sv
// Sequencer driving the enable/address inputs of a one-hot decoder. Accepts a command
// in IDLE, then walks the address from start to end (up, down or a single address),
// holding each address for dwell+1 cycles, and finishes with a one-cycle done pulse.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cmd_valid_i/ready_o  command handshake (ready only in IDLE)
//   cmd_mode_i           00 single, 01 up, 10 down, 11 reserved
//   cmd_start_i/end_i    first / last address (end ignored in single mode)
//   cmd_dwell_i          hold cycles per address minus one
//   abort_i              terminate the active command
//   dec_en_o, dec_addr_o decoder enable and address
//   step_o               pulse on the first cycle of each new address
//   busy_o               high while sweeping
//   done_o, status_o     completion pulse and status (00 ok, 01 aborted, 10 bad mode)
module decoder_sweep_ctrl
  import decoder_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_mode_i,
  input  logic [ADDR_W-1:0]  cmd_start_i,
  input  logic [ADDR_W-1:0]  cmd_end_i,
  input  logic [DWELL_W-1:0] cmd_dwell_i,
  input  logic               abort_i,
  output logic               dec_en_o,
  output logic [ADDR_W-1:0]  dec_addr_o,
  output logic               step_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         status_o
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  end_q, end_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ready_q, ready_d;
  logic               en_q, en_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         status_q, status_d;

  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DWELL_W-1:0] cnt_load_val;

  decoder_dwell_cnt #(
    .Width (DWELL_W)
  ) u_dwell_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    end_d        = end_q;
    dwell_d      = dwell_q;
    addr_d       = addr_q;
    ready_d      = ready_q;
    en_d         = en_q;
    step_d       = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    status_d     = status_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = dwell_q;

    unique case (state_q)
      StIdle: begin
        // ready_q is always high here, so cmd_valid_i alone completes the handshake;
        // abort_i is deliberately not looked at.
        if (cmd_valid_i) begin
          mode_d  = cmd_mode_i;
          end_d   = cmd_end_i;
          dwell_d = cmd_dwell_i;
          ready_d = 1'b0;
          if (cmd_mode_i == MODE_RSVD) begin
            state_d  = StFin;
            done_d   = 1'b1;
            status_d = ST_BADMODE;
          end else begin
            state_d      = StActive;
            en_d         = 1'b1;
            busy_d       = 1'b1;
            step_d       = 1'b1;
            addr_d       = cmd_start_i;
            cnt_load     = 1'b1;
            cnt_load_val = cmd_dwell_i;
          end
        end
      end
      StActive: begin
        if (abort_i || (cnt_zero && ((mode_q == MODE_SINGLE) || (addr_q == end_q)))) begin
          state_d  = StFin;
          en_d     = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          status_d = abort_i ? ST_ABORT : ST_OK;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          // Address arithmetic wraps modulo 2**ADDR_W.
          addr_d   = (mode_q == MODE_UP) ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
          step_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      mode_q   <= MODE_SINGLE;
      end_q    <= '0;
      dwell_q  <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b1;
      en_q     <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      end_q    <= end_d;
      dwell_q  <= dwell_d;
      addr_q   <= addr_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign dec_en_o    = en_q;
  assign dec_addr_o  = addr_q;
  assign step_o      = step_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign status_o    = status_q;

endmodule

// File: tb/tb_decoder_sweep_ctrl.sv
// Directed bench for decoder_sweep_ctrl: a table of commands with hand-computed
// address sequences, done cycle and status, checked cycle by cycle, plus a hand-written
// mid-sweep reset sequence.
module tb_decoder_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [5:0] cmd_start;
  logic [5:0] cmd_end;
  logic [7:0] cmd_dwell;
  logic       abort;
  logic       dec_en;
  logic [5:0] dec_addr;
  logic       step;
  logic       busy;
  logic       done;
  logic [1:0] status;

  int n_vec;
  int n_err;

  decoder_sweep_ctrl #(
    .ADDR_W  (6),
    .DWELL_W (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_mode_i  (cmd_mode),
    .cmd_start_i (cmd_start),
    .cmd_end_i   (cmd_end),
    .cmd_dwell_i (cmd_dwell),
    .abort_i     (abort),
    .dec_en_o    (dec_en),
    .dec_addr_o  (dec_addr),
    .step_o      (step),
    .busy_o      (busy),
    .done_o      (done),
    .status_o    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation packed as {ready, en, busy, step, done, addr[5:0], status[1:0]}.
  function automatic logic [12:0] pack(input logic r, input logic e, input logic b,
                                       input logic s, input logic d, input logic [5:0] a,
                                       input logic [1:0] st);
    return {r, e, b, s, d, a, st};
  endfunction

  task automatic check(input string name, input int idx, input int cyc,
                       input logic [12:0] exp_v);
    logic [12:0] act;
    act = pack(cmd_ready, dec_en, busy, step, done, dec_addr, status);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s vec=%0d cyc=%0d got rdy/en/busy/step/done/addr/st=%b required=%b",
               name, idx, cyc, act, exp_v);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [5:0] start;
    logic [5:0] fin;
    logic [7:0] dwell;
    int         dir;        // address change per step: +1, -1 or 0
    int         abort_at;   // cycle during which abort is held, -1 for none
    bit         abort_idle; // abort raised together with cmd_valid
    int         done_cyc;   // cycle (1 = first after accept) carrying done
    logic [1:0] st;
  } vec_t;

  vec_t vecs[10];
  logic [1:0] prev_status;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_start = '0;
    cmd_end   = '0;
    cmd_dwell = '0;
    abort     = 1'b0;
    n_vec     = 0;
    n_err     = 0;

    vecs[0] = '{2'b01, 6'd5,  6'd8,  8'd2,   1, -1, 1'b0, 13,  2'b00};
    vecs[1] = '{2'b10, 6'd1,  6'd62, 8'd0,  -1, -1, 1'b0, 5,   2'b00};
    vecs[2] = '{2'b00, 6'd40, 6'd10, 8'd5,   0, -1, 1'b0, 7,   2'b00};
    vecs[3] = '{2'b01, 6'd62, 6'd1,  8'd1,   1, -1, 1'b0, 9,   2'b00};
    vecs[4] = '{2'b01, 6'd20, 6'd20, 8'd0,   1, -1, 1'b0, 2,   2'b00};
    vecs[5] = '{2'b01, 6'd5,  6'd8,  8'd2,   1,  5, 1'b0, 6,   2'b01};
    vecs[6] = '{2'b01, 6'd5,  6'd8,  8'd2,   1, -1, 1'b1, 13,  2'b00};
    vecs[7] = '{2'b01, 6'd0,  6'd63, 8'd0,   1, -1, 1'b0, 65,  2'b00};
    vecs[8] = '{2'b10, 6'd7,  6'd7,  8'd255, -1, -1, 1'b0, 257, 2'b00};
    vecs[9] = '{2'b11, 6'd3,  6'd9,  8'd4,   0, -1, 1'b0, 1,   2'b10};

    #12;
    check("reset_state", -1, 0, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", -1, 0, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00));
    prev_status = 2'b00;

    for (int v = 0; v < 10; v++) begin
      cmd_valid = 1'b1;
      cmd_mode  = vecs[v].mode;
      cmd_start = vecs[v].start;
      cmd_end   = vecs[v].fin;
      cmd_dwell = vecs[v].dwell;
      abort     = vecs[v].abort_idle;
      @(posedge clk);
      for (int k = 1; k <= vecs[v].done_cyc; k++) begin
        @(negedge clk);
        if (k == 1) begin
          // Scramble the command bus: it must have been latched at accept.
          cmd_valid = 1'b0;
          cmd_mode  = ~vecs[v].mode;
          cmd_start = 6'd33;
          cmd_end   = 6'd33;
          cmd_dwell = 8'd9;
        end
        if (k == vecs[v].done_cyc) begin
          check("done_cycle", v, k, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, dec_addr_exp(v, k - 1),
                                         vecs[v].st));
        end else begin
          check("active_cycle", v, k, pack(1'b0, 1'b1, 1'b1,
                                           ((k - 1) % (int'(vecs[v].dwell) + 1)) == 0,
                                           1'b0, dec_addr_exp(v, k), prev_status));
        end
        abort = (k == vecs[v].abort_at);
      end
      abort = 1'b0;
      @(negedge clk);
      check("back_to_idle", v, vecs[v].done_cyc + 1,
            pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dec_addr_exp(v, vecs[v].done_cyc - 1),
                 vecs[v].st));
      prev_status = vecs[v].st;
    end

    // Mid-sweep asynchronous reset: up 0->63, dwell 3. Status is 10 beforehand.
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    cmd_start = 6'd0;
    cmd_end   = 6'd63;
    cmd_dwell = 8'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 2; k <= 10; k++) @(negedge clk);
    check("pre_reset_sweep", 100, 10, pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd2, 2'b10));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 100, 0, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("held_in_reset", 100, k, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_after_release", 100, k, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Expected address during cycle k of vector v, from the table's start/dir/dwell.
  // For mode 11 the address register was never loaded, so it keeps the prior value,
  // which is the last address of vector 8 (7).
  function automatic logic [5:0] dec_addr_exp(input int v, input int k);
    int a;
    if (vecs[v].mode == 2'b11) return 6'd7;
    if (k < 1) k = 1;
    a = int'(vecs[v].start) + vecs[v].dir * ((k - 1) / (int'(vecs[v].dwell) + 1));
    return 6'(a);
  endfunction

endmodule
